// File: rtl/lfsr_checker.sv
// LFSR sequence checker: seeds from the received stream, locks after a run of
// correct predictions, then flywheels the prediction and counts mismatches.
module lfsr_checker #(
  parameter int LOCK_THRESH = 4,
  parameter int LOSS_THRESH = 3,
  parameter int ERR_W       = 16
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [15:0]      in_data,
  output logic [1:0]       state,
  output logic             locked,
  output logic [15:0]      expected,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_T = 4'(LOCK_THRESH);
  localparam logic [3:0] LOSS_T = 4'(LOSS_THRESH);

  state_t           state_q, state_d;
  logic [15:0]      expected_q, expected_d;
  logic [3:0]       match_q, match_d;
  logic [3:0]       miss_q, miss_d;
  logic [ERR_W-1:0] errCnt_q, errCnt_d;
  logic             errPulse_q, errPulse_d;
  logic             locked_q, locked_d;

  logic             isMatch;
  logic             isZero;
  logic [3:0]       matchInc;
  logic [3:0]       missInc;
  logic [ERR_W-1:0] errInc;

  function automatic logic [15:0] lfsrNext(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[4] ^ x[2] ^ x[1]};
  endfunction

  assign isMatch  = (in_data == expected_q);
  assign isZero   = (in_data == 16'h0000);
  assign matchInc = (match_q == 4'hF) ? match_q : match_q + 4'd1;
  assign missInc  = (miss_q == 4'hF) ? miss_q : miss_q + 4'd1;
  assign errInc   = (errCnt_q == '1) ? errCnt_q : errCnt_q + ERR_W'(1);

  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    match_d    = match_q;
    miss_d     = miss_q;
    errCnt_d   = errCnt_q;
    errPulse_d = 1'b0;

    if (in_valid) begin
      unique case (state_q)
        SEED: begin
          match_d = 4'd0;
          if (!isZero) begin
            expected_d = lfsrNext(in_data);
            state_d    = ACQ;
          end
        end
        ACQ: begin
          if (isZero) begin
            match_d = 4'd0;
            state_d = SEED;
          end else if (isMatch) begin
            expected_d = lfsrNext(in_data);
            match_d    = matchInc;
            if (matchInc >= LOCK_T) begin
              state_d = LOCKED;
              miss_d  = 4'd0;
            end
          end else begin
            expected_d = lfsrNext(in_data);
            match_d    = 4'd0;
          end
        end
        LOCKED: begin
          // Once locked the prediction runs freely so one bad word cannot derail it.
          expected_d = lfsrNext(expected_q);
          if (isMatch) begin
            miss_d = 4'd0;
          end else begin
            errPulse_d = 1'b1;
            errCnt_d   = errInc;
            miss_d     = missInc;
            if (missInc >= LOSS_T) begin
              match_d = 4'd0;
              miss_d  = 4'd0;
              if (isZero) begin
                state_d = SEED;
              end else begin
                state_d    = ACQ;
                expected_d = lfsrNext(in_data);
              end
            end
          end
        end
        default: begin
          state_d = SEED;
          match_d = 4'd0;
          miss_d  = 4'd0;
        end
      endcase
    end

    if (clear) begin
      errCnt_d = '0;
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= SEED;
      expected_q <= 16'h0000;
      match_q    <= 4'd0;
      miss_q     <= 4'd0;
      errCnt_q   <= '0;
      errPulse_q <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      match_q    <= match_d;
      miss_q     <= miss_d;
      errCnt_q   <= errCnt_d;
      errPulse_q <= errPulse_d;
      locked_q   <= locked_d;
    end
  end

  assign state     = state_q;
  assign locked    = locked_q;
  assign expected  = expected_q;
  assign err_pulse = errPulse_q;
  assign err_cnt   = errCnt_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: one default instance and one with a
// 2-bit error counter and a large loss threshold for saturation/clear checks.
module tb_lfsr_checker;

  logic        CLK;
  logic        RSTn;

  logic        clear1, inValid1;
  logic [15:0] inData1;
  logic [1:0]  state1;
  logic        locked1, errPulse1;
  logic [15:0] expected1, errCnt1;

  logic        clear2, inValid2;
  logic [15:0] inData2;
  logic [1:0]  state2;
  logic        locked2, errPulse2;
  logic [15:0] expected2;
  logic [1:0]  errCnt2;

  int testsRun  = 0;
  int failCount = 0;

  typedef struct {
    int          dutSel;
    string       name;
    logic [1:0]  st;
    logic [15:0] ex;
    bit          chkEx;
    logic        pu;
    logic [15:0] cnt;
  } expItem_t;

  expItem_t sbQ[$];
  expItem_t item;

  lfsr_checker dut1 (
    .CLK(CLK), .RSTn(RSTn), .clear(clear1), .in_valid(inValid1),
    .in_data(inData1), .state(state1), .locked(locked1),
    .expected(expected1), .err_pulse(errPulse1), .err_cnt(errCnt1)
  );

  lfsr_checker #(.LOCK_THRESH(4), .LOSS_THRESH(15), .ERR_W(2)) dut2 (
    .CLK(CLK), .RSTn(RSTn), .clear(clear2), .in_valid(inValid2),
    .in_data(inData2), .state(state2), .locked(locked2),
    .expected(expected2), .err_pulse(errPulse2), .err_cnt(errCnt2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
    testsRun++;
    if (act !== req) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%04h, want 0x%04h", name, act, req);
    end
  endtask

  // Drives one cycle of stimulus and queues the response expected after the edge.
  task automatic applyStimulus(input int d, input logic v, input logic [15:0] data,
                               input logic clr, input string name, input logic [1:0] st,
                               input logic [15:0] ex, input bit chkEx, input logic pu,
                               input logic [15:0] cnt);
    expItem_t e;
    @(negedge CLK);
    if (d == 1) begin
      inValid1 = v; inData1 = data; clear1 = clr;
      inValid2 = 1'b0; clear2 = 1'b0;
    end else begin
      inValid2 = v; inData2 = data; clear2 = clr;
      inValid1 = 1'b0; clear1 = 1'b0;
    end
    e.dutSel = d; e.name = name; e.st = st; e.ex = ex;
    e.chkEx = chkEx; e.pu = pu; e.cnt = cnt;
    sbQ.push_back(e);
  endtask

  always @(posedge CLK) begin
    #1;
    if (sbQ.size() != 0) begin
      item = sbQ.pop_front();
      if (item.dutSel == 1) begin
        checkOutput({item.name, ".state"}, {14'd0, state1}, {14'd0, item.st});
        checkOutput({item.name, ".locked"}, {15'd0, locked1}, {15'd0, item.st == 2'd2});
        if (item.chkEx) checkOutput({item.name, ".expected"}, expected1, item.ex);
        checkOutput({item.name, ".err_pulse"}, {15'd0, errPulse1}, {15'd0, item.pu});
        checkOutput({item.name, ".err_cnt"}, errCnt1, item.cnt);
      end else begin
        checkOutput({item.name, ".state"}, {14'd0, state2}, {14'd0, item.st});
        checkOutput({item.name, ".locked"}, {15'd0, locked2}, {15'd0, item.st == 2'd2});
        if (item.chkEx) checkOutput({item.name, ".expected"}, expected2, item.ex);
        checkOutput({item.name, ".err_pulse"}, {15'd0, errPulse2}, {15'd0, item.pu});
        checkOutput({item.name, ".err_cnt"}, {14'd0, errCnt2}, item.cnt);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RSTn = 1'b0;
    clear1 = 1'b0; inValid1 = 1'b0; inData1 = 16'h0;
    clear2 = 1'b0; inValid2 = 1'b0; inData2 = 16'h0;
    #1;
    checkOutput("reset.state", {14'd0, state1}, 16'd0);
    checkOutput("reset.locked", {15'd0, locked1}, 16'd0);
    checkOutput("reset.expected", expected1, 16'h0000);
    checkOutput("reset.err_pulse", {15'd0, errPulse1}, 16'd0);
    checkOutput("reset.err_cnt", errCnt1, 16'd0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;

    // Zero seed, then acquisition with idle gaps in the stream.
    applyStimulus(1, 1, 16'h0000, 0, "seedZero", 2'd0, 16'h0000, 1, 0, 16'd0);
    applyStimulus(1, 1, 16'h0001, 0, "seed1",    2'd1, 16'h0002, 1, 0, 16'd0);
    applyStimulus(1, 0, 16'hDEAD, 0, "gapA",     2'd1, 16'h0002, 1, 0, 16'd0);
    applyStimulus(1, 1, 16'h0002, 0, "acq2",     2'd1, 16'h0005, 1, 0, 16'd0);
    applyStimulus(1, 1, 16'h0005, 0, "acq5",     2'd1, 16'h000B, 1, 0, 16'd0);
    applyStimulus(1, 0, 16'h0000, 0, "gapB",     2'd1, 16'h000B, 1, 0, 16'd0);
    applyStimulus(1, 1, 16'h000B, 0, "acqB",     2'd1, 16'h0017, 1, 0, 16'd0);
    applyStimulus(1, 1, 16'h0017, 0, "lock17",   2'd2, 16'h002F, 1, 0, 16'd0);

    // Single corrupted word while locked; prediction flywheels past it.
    applyStimulus(1, 1, 16'hFFFF, 0, "errOne",   2'd2, 16'h005E, 1, 1, 16'd1);
    applyStimulus(1, 1, 16'h005E, 0, "resume5E", 2'd2, 16'h00BD, 1, 0, 16'd1);
    applyStimulus(1, 1, 16'h00BD, 0, "resumeBD", 2'd2, 16'h017A, 1, 0, 16'd1);
    applyStimulus(1, 1, 16'h017A, 1, "clrMatch", 2'd2, 16'h02F4, 1, 0, 16'd0);

    // Three consecutive misses drop lock and reseed from the third word.
    applyStimulus(1, 1, 16'h1234, 0, "loss1",    2'd2, 16'h05E8, 1, 1, 16'd1);
    applyStimulus(1, 1, 16'h1234, 0, "loss2",    2'd2, 16'h0BD0, 1, 1, 16'd2);
    applyStimulus(1, 1, 16'h0003, 0, "loss3",    2'd1, 16'h0007, 1, 1, 16'd3);
    applyStimulus(1, 1, 16'h0004, 0, "acqReseed",2'd1, 16'h0009, 1, 0, 16'd3);
    applyStimulus(1, 1, 16'h0009, 0, "reacq9",   2'd1, 16'h0012, 1, 0, 16'd3);
    applyStimulus(1, 1, 16'h0012, 0, "reacq12",  2'd1, 16'h0024, 1, 0, 16'd3);
    applyStimulus(1, 1, 16'h0024, 0, "reacq24",  2'd1, 16'h0049, 1, 0, 16'd3);
    applyStimulus(1, 1, 16'h0049, 0, "relock49", 2'd2, 16'h0092, 1, 0, 16'd3);

    // Asynchronous reset in the middle of a clock period while locked.
    @(posedge CLK);
    #3;
    RSTn = 1'b0;
    inValid1 = 1'b0;
    #1;
    checkOutput("asyncRst.state", {14'd0, state1}, 16'd0);
    checkOutput("asyncRst.locked", {15'd0, locked1}, 16'd0);
    checkOutput("asyncRst.expected", expected1, 16'h0000);
    checkOutput("asyncRst.err_pulse", {15'd0, errPulse1}, 16'd0);
    checkOutput("asyncRst.err_cnt", errCnt1, 16'd0);
    @(negedge CLK);
    RSTn = 1'b1;
    applyStimulus(1, 1, 16'h0001, 0, "postRstSeed", 2'd1, 16'h0002, 1, 0, 16'd0);
    applyStimulus(1, 1, 16'h0000, 0, "acqZero",     2'd0, 16'h0000, 0, 0, 16'd0);

    // Saturating 2-bit counter and clear racing a mismatch.
    applyStimulus(2, 1, 16'h0001, 0, "sat.seed", 2'd1, 16'h0002, 1, 0, 16'd0);
    applyStimulus(2, 1, 16'h0002, 0, "sat.acq2", 2'd1, 16'h0005, 1, 0, 16'd0);
    applyStimulus(2, 1, 16'h0005, 0, "sat.acq5", 2'd1, 16'h000B, 1, 0, 16'd0);
    applyStimulus(2, 1, 16'h000B, 0, "sat.acqB", 2'd1, 16'h0017, 1, 0, 16'd0);
    applyStimulus(2, 1, 16'h0017, 0, "sat.lock", 2'd2, 16'h002F, 1, 0, 16'd0);
    applyStimulus(2, 1, 16'hFFFF, 0, "sat.err1", 2'd2, 16'h005E, 1, 1, 16'd1);
    applyStimulus(2, 1, 16'hFFFF, 0, "sat.err2", 2'd2, 16'h00BD, 1, 1, 16'd2);
    applyStimulus(2, 1, 16'hFFFF, 0, "sat.err3", 2'd2, 16'h017A, 1, 1, 16'd3);
    applyStimulus(2, 1, 16'hFFFF, 0, "sat.hold", 2'd2, 16'h02F4, 1, 1, 16'd3);
    applyStimulus(2, 1, 16'hFFFF, 1, "sat.clr",  2'd2, 16'h05E8, 1, 1, 16'd0);
    applyStimulus(2, 1, 16'hFFFF, 0, "sat.after",2'd2, 16'h0BD0, 1, 1, 16'd1);

    @(negedge CLK);
    inValid1 = 1'b0; inValid2 = 1'b0; clear1 = 1'b0; clear2 = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("scoreboardDrained", 16'(sbQ.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
